// File: rtl/pixel_feeder.sv
// pixel_feeder: buffers a quantised 20x20 frame and bursts it out 5 pixels per beat; define PIX_QUANT_ROUND_EN for rounding quantisation
module pixel_feeder #(
  parameter int IN_WIDTH = 8,
  parameter int PIX_WIDTH = 5,
  parameter int IMG_DIM = 20,
  parameter int LANES = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_valid,
  input  logic [IN_WIDTH-1:0]  pix_in,
  output logic                 pix_ready,
  output logic                 frame_ready,
  input  logic                 frame_req,
  output logic [PIX_WIDTH-1:0] pixel_in0,
  output logic [PIX_WIDTH-1:0] pixel_in1,
  output logic [PIX_WIDTH-1:0] pixel_in2,
  output logic [PIX_WIDTH-1:0] pixel_in3,
  output logic [PIX_WIDTH-1:0] pixel_in4,
  output logic                 load_end,
  output logic                 overrun
);
  localparam int DEPTH = IMG_DIM * IMG_DIM;
  localparam int BEATS = DEPTH / LANES;
  localparam int AW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(BEATS);
  localparam int SH = IN_WIDTH - PIX_WIDTH;
  typedef enum logic [1:0] {FILL, READY, BURST} state_t;
  state_t state;
  logic [AW-1:0] wr_cnt, rd_base;
  logic [BW-1:0] beat_cnt;
  logic [PIX_WIDTH-1:0] mem [DEPTH];
  logic [PIX_WIDTH-1:0] lane [LANES];
  logic [PIX_WIDTH-1:0] quant;
  logic accept, last_wr, last_beat;
`ifdef PIX_QUANT_ROUND_EN
  localparam logic [IN_WIDTH:0] HALF = {{IN_WIDTH{1'b0}}, 1'b1} << (SH - 1);
  logic [IN_WIDTH:0] biased;
  assign biased = {1'b0, pix_in} + HALF;
  assign quant = biased[IN_WIDTH] ? '1 : PIX_WIDTH'(biased >> SH);
`else
  assign quant = PIX_WIDTH'(pix_in >> SH);
`endif
  assign pix_ready = (state == FILL) && !reset;
  assign accept = pix_valid && pix_ready;
  assign last_wr = wr_cnt == AW'(DEPTH - 1);
  assign last_beat = beat_cnt == BW'(BEATS - 1);
  // READY loads beat 0; BURST preloads the beat after the one being driven
  assign rd_base = (state == BURST) ? (AW'(beat_cnt) + 1'b1) * AW'(LANES) : '0;
  assign pixel_in0 = lane[0];
  assign pixel_in1 = lane[1];
  assign pixel_in2 = lane[2];
  assign pixel_in3 = lane[3];
  assign pixel_in4 = lane[4];
  always_ff @(posedge clk)
    if (accept) mem[wr_cnt[AW-1:0]] <= quant;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
      wr_cnt <= '0;
      beat_cnt <= '0;
      frame_ready <= 1'b0;
      load_end <= 1'b0;
      overrun <= 1'b0;
      for (int j = 0; j < LANES; j++) lane[j] <= '0;
    end else begin
      overrun <= frame_req && (state != READY);
      case (state)
        FILL: if (accept) begin
          wr_cnt <= last_wr ? '0 : wr_cnt + 1'b1;
          if (last_wr) begin
            state <= READY;
            frame_ready <= 1'b1;
          end
        end
        READY: if (frame_req) begin
          state <= BURST;
          frame_ready <= 1'b0;
          beat_cnt <= '0;
          load_end <= 1'b0;
          for (int j = 0; j < LANES; j++) lane[j] <= mem[rd_base + AW'(j)];
        end
        BURST: if (last_beat) begin
          state <= FILL;
          beat_cnt <= '0;
          load_end <= 1'b0;
          for (int j = 0; j < LANES; j++) lane[j] <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
          load_end <= beat_cnt == BW'(BEATS - 2);
          for (int j = 0; j < LANES; j++) lane[j] <= mem[rd_base + AW'(j)];
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_feeder.sv
// tb_pixel_feeder: directed fill/burst vectors for pixel_feeder with a small quantisation model
module tb_pixel_feeder;
  logic clk = 1'b0, reset = 1'b1, pix_valid = 1'b0, frame_req = 1'b0;
  logic [7:0] pix_in = '0;
  logic pix_ready, frame_ready, load_end, overrun;
  logic [4:0] p0, p1, p2, p3, p4;
  logic [24:0] lanes, first_beat;
  int n_cmp = 0, n_err = 0;
  int vals [400];
  assign lanes = {p4, p3, p2, p1, p0};
  always #5 clk = ~clk;
  pixel_feeder dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_ready(pix_ready), .frame_ready(frame_ready), .frame_req(frame_req),
    .pixel_in0(p0), .pixel_in1(p1), .pixel_in2(p2), .pixel_in3(p3), .pixel_in4(p4),
    .load_end(load_end), .overrun(overrun)
  );
  function automatic int q(int x);
`ifdef PIX_QUANT_ROUND_EN
    int r = (x + 4) >> 3;
    return r > 31 ? 31 : r;
`else
    return x >> 3;
`endif
  endfunction
  function automatic logic [24:0] beat_exp(int k);
    logic [24:0] e;
    for (int j = 0; j < 5; j++) e[5*j +: 5] = 5'(q(vals[5*k+j]));
    return e;
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic fill(input bit gaps, input bit ovr, input bit held);
    int acc = 0, cyc = 0;
    while (acc < 400 && cyc < 4000) begin
      @(negedge clk);
      if (held && cyc > 0) begin
        check("ovr_held_fill", overrun, 1);
        check("lanes_fill", lanes, 0);
      end
      if (ovr && cyc == 20) frame_req = 1'b1;
      if (ovr && cyc == 21) begin
        frame_req = 1'b0;
        check("ovr_fill", overrun, 1);
      end
      if (ovr && cyc == 22) check("ovr_fill_clr", overrun, 0);
      pix_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      pix_in = 8'(vals[acc]);
      if (pix_valid && pix_ready) acc++;
      cyc++;
    end
    check("fill_count", acc, 400);
    check("fr_before", frame_ready, 0);
    @(negedge clk);
    pix_valid = 1'b0;
    check("fr_after", frame_ready, 1);
    check("pr_after", pix_ready, 0);
    check("lanes_idle", lanes, 0);
    check("le_idle", load_end, 0);
  endtask
  task automatic burst(input bit held, input int ovr_at, input int rst_at);
    frame_req = 1'b1;
    @(negedge clk);
    if (!held) frame_req = 1'b0;
    for (int k = 0; k < 80; k++) begin
      check("beat", lanes, beat_exp(k));
      check("load_end", load_end, k == 79);
      if (k == 0) begin
        first_beat = lanes;
        check("ovr_start", overrun, 0);
      end
      if (held && k > 0) check("ovr_held_burst", overrun, 1);
      if (ovr_at >= 0 && k == ovr_at) frame_req = 1'b1;
      if (ovr_at >= 0 && k == ovr_at + 1) begin
        frame_req = 1'b0;
        check("ovr_burst", overrun, 1);
      end
      if (ovr_at >= 0 && k == ovr_at + 2) check("ovr_burst_clr", overrun, 0);
      if (k == rst_at) begin
        reset = 1'b1;
        #1;
        check("rst_lanes", lanes, 0);
        check("rst_le", load_end, 0);
        check("rst_pr", pix_ready, 0);
        return;
      end
      @(negedge clk);
    end
    check("post_lanes", lanes, 0);
    check("post_le", load_end, 0);
    check("post_pr", pix_ready, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    check("reset_pr", pix_ready, 0);
    check("reset_fr", frame_ready, 0);
    check("reset_lanes", lanes, 0);
    check("reset_ovr", overrun, 0);
    reset = 1'b0;
    #1 check("release_pr", pix_ready, 1);
    for (int i = 0; i < 400; i++) vals[i] = i % 256;
    fill(0, 0, 0);
    burst(0, -1, 1000);
    for (int i = 0; i < 400; i++) vals[i] = (i * 7 + 3) % 256;
    fill(1, 1, 0);
    burst(0, 40, 1000);
    for (int i = 0; i < 400; i++) vals[i] = (i + 100) % 256;
    fill(0, 0, 0);
    burst(0, -1, 40);
    @(negedge clk);
    check("rst_held_pr", pix_ready, 0);
    reset = 1'b0;
    #1 check("rst_rel_pr", pix_ready, 1);
    check("rst_rel_fr", frame_ready, 0);
    for (int i = 0; i < 400; i++) vals[i] = 255 - (i % 256);
    fill(0, 0, 0);
    burst(0, -1, 1000);
    for (int i = 0; i < 400; i++) vals[i] = i % 256;
    vals[0] = 255; vals[1] = 252; vals[2] = 251; vals[3] = 4; vals[4] = 3;
    fill(0, 0, 0);
    burst(0, -1, 1000);
`ifdef PIX_QUANT_ROUND_EN
    check("quant", first_beat, {5'd0, 5'd1, 5'd31, 5'd31, 5'd31});
`else
    check("quant", first_beat, {5'd0, 5'd0, 5'd31, 5'd31, 5'd31});
`endif
    for (int i = 0; i < 400; i++) vals[i] = (3 * i) % 256;
    frame_req = 1'b1;
    fill(0, 0, 1);
    burst(1, -1, 1000);
    for (int i = 0; i < 400; i++) vals[i] = (5 * i + 1) % 256;
    fill(1, 0, 1);
    burst(1, -1, 1000);
    frame_req = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
